pc_return_stack: RTL and testbench

Parametrised hardware return-address stack for the processor's PC path. It serves the datapath's push, pop and RET hooks. It replaces a fixed, unconnected stack with configurable address width, depth and overflow policy, and adds occupancy reporting and sticky error flags. The controller drives push on call, pop on RET, and the PC-select mux takes `top` as the return target.

---
 rtl/pc_return_stack.sv | 141 ++++++++++++++
 tb/tb_pc_return_stack.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_return_stack.sv
// pc_return_stack
//   Return-address stack for the PC path. Calls push PC+1, RET pops, and the
//   PC-select mux takes `top` as the return target in the pop cycle.
//   Storage is a circular register array addressed by the oldest entry (r_base)
//   and the occupancy (r_count). A full stack either drops a new push or
//   discards the oldest entry, depending on WRAP_MODE.
//
// Parameters
//   ADDR_W     width of a stored return address
//   DEPTH      number of entries (power of two, >= 2)
//   WRAP_MODE  0 = saturate on overflow, 1 = circular (oldest discarded)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   push       write push_data as the new top
//   pop        remove the current top
//   push_data  return address to push
//   clr_err    clear sticky overflow/underflow
//   top        current top entry, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: push while full without pop
//   underflow  sticky: pop while empty
module pc_return_stack #(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [ADDR_W-1:0]       push_data,
  input  logic                    clr_err,
  output logic [ADDR_W-1:0]       top,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [IW-1:0]     r_base;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_udf;

  logic          w_empty;
  logic          w_full;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_push_idx;
  logic          w_wr_en;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_base_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_set_ovf;
  logic          w_set_udf;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Index arithmetic is modulo DEPTH through IW-bit truncation; when full the
  // low count bits are zero, so the push slot coincides with r_base.
  assign w_push_idx = r_base + r_count[IW-1:0];
  assign w_top_idx  = w_push_idx - IW'(1);

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = w_push_idx;
    w_base_nxt  = r_base;
    w_count_nxt = r_count;
    w_set_ovf   = 1'b0;
    w_set_udf   = 1'b0;
    if (push && pop) begin
      w_wr_en = 1'b1;
      if (w_empty) begin
        // The pop half has nothing to remove; the push still lands.
        w_set_udf   = 1'b1;
        w_count_nxt = CW'(1);
      end else begin
        // Replace the top in place: occupancy unchanged, never an overflow.
        w_wr_idx = w_top_idx;
      end
    end else if (push) begin
      if (!w_full) begin
        w_wr_en     = 1'b1;
        w_count_nxt = r_count + CW'(1);
      end else begin
        w_set_ovf = 1'b1;
        if (WRAP_MODE != 0) begin
          // Overwrite the oldest slot and advance base so it becomes the top.
          w_wr_en    = 1'b1;
          w_wr_idx   = r_base;
          w_base_nxt = r_base + IW'(1);
        end
      end
    end else if (pop) begin
      if (w_empty) begin
        w_set_udf = 1'b1;
      end else begin
        w_count_nxt = r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_base  <= w_base_nxt;
      r_count <= w_count_nxt;
      // A new error in the same cycle as clr_err keeps the flag set.
      r_ovf   <= w_set_ovf | (r_ovf & ~clr_err);
      r_udf   <= w_set_udf | (r_udf & ~clr_err);
    end
  end

  // Array contents are don't-care after reset, so no reset on storage.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  assign top       = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_pc_return_stack.sv
module tb_pc_return_stack;

  localparam int AW = 12;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst, push, pop, clr_err;
  logic [AW-1:0] push_data;

  logic [AW-1:0] top_s, top_w;
  logic [3:0]    cnt_s, cnt_w;
  logic          emp_s, emp_w, ful_s, ful_w, ovf_s, ovf_w, udf_s, udf_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_return_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP_MODE(0)) u_sat (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_err(clr_err), .top(top_s), .count(cnt_s), .empty(emp_s),
    .full(ful_s), .overflow(ovf_s), .underflow(udf_s));

  pc_return_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_err(clr_err), .top(top_w), .count(cnt_w), .empty(emp_w),
    .full(ful_w), .overflow(ovf_w), .underflow(udf_w));

  typedef struct {
    string      name;
    logic       rst, push, pop, clr;
    logic [11:0] data;
    int         cs, ts, os, us;   // saturating instance: count, top, ovf, udf
    int         cw, tw, ow, uw;   // wrapping instance
  } vec_t;

  vec_t vecs[$];

  // Reference model: stack as a plain array, index 0 = oldest.
  int st [2][DP];
  int m_cnt [2];
  int m_ovf [2];
  int m_udf [2];

  task automatic add(input string nm, input logic r, input logic ps, input logic pp,
                     input logic cl, input int d,
                     input int cs, input int ts, input int os, input int us,
                     input int cw, input int tw, input int ow, input int uw);
    vec_t v;
    v.name = nm; v.rst = r; v.push = ps; v.pop = pp; v.clr = cl; v.data = d[11:0];
    v.cs = cs; v.ts = ts; v.os = os; v.us = us;
    v.cw = cw; v.tw = tw; v.ow = ow; v.uw = uw;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  task automatic check_all(input string nm,
                           input int cs, input int ts, input int os, input int us,
                           input int cw, input int tw, input int ow, input int uw);
    chk(nm, "sat.count",     int'(cnt_s), cs);
    chk(nm, "sat.top",       int'(top_s), ts);
    chk(nm, "sat.empty",     int'(emp_s), int'(cs == 0));
    chk(nm, "sat.full",      int'(ful_s), int'(cs == DP));
    chk(nm, "sat.overflow",  int'(ovf_s), os);
    chk(nm, "sat.underflow", int'(udf_s), us);
    chk(nm, "wrap.count",    int'(cnt_w), cw);
    chk(nm, "wrap.top",      int'(top_w), tw);
    chk(nm, "wrap.empty",    int'(emp_w), int'(cw == 0));
    chk(nm, "wrap.full",     int'(ful_w), int'(cw == DP));
    chk(nm, "wrap.overflow", int'(ovf_w), ow);
    chk(nm, "wrap.underflow",int'(udf_w), uw);
  endtask

  task automatic model_step(input int m, input logic r, input logic ps, input logic pp,
                            input logic cl, input int d);
    int so, su;
    so = 0; su = 0;
    if (r) begin
      m_cnt[m] = 0; m_ovf[m] = 0; m_udf[m] = 0;
      return;
    end
    if (ps && pp) begin
      if (m_cnt[m] == 0) begin
        su = 1; st[m][0] = d; m_cnt[m] = 1;
      end else begin
        st[m][m_cnt[m]-1] = d;
      end
    end else if (ps) begin
      if (m_cnt[m] < DP) begin
        st[m][m_cnt[m]] = d; m_cnt[m]++;
      end else begin
        so = 1;
        if (m == 1) begin
          for (int i = 0; i < DP-1; i++) st[m][i] = st[m][i+1];
          st[m][DP-1] = d;
        end
      end
    end else if (pp) begin
      if (m_cnt[m] == 0) su = 1;
      else m_cnt[m]--;
    end
    m_ovf[m] = so | (m_ovf[m] & int'(!cl));
    m_udf[m] = su | (m_udf[m] & int'(!cl));
  endtask

  function automatic int m_top(input int m);
    return (m_cnt[m] == 0) ? 0 : st[m][m_cnt[m]-1];
  endfunction

  task automatic apply(input logic r, input logic ps, input logic pp,
                       input logic cl, input int d);
    @(negedge clk);
    rst = r; push = ps; pop = pp; clr_err = cl; push_data = d[AW-1:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;

    // Reset with push asserted must still yield an empty stack.
    add("reset0", 1,1,0,0,'h055, 0,0,0,0, 0,0,0,0);
    add("reset1", 1,1,0,0,'h056, 0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 8; i++)
      add("fill100", 0,1,0,0,'h100+i, i+1,'h100+i,0,0, i+1,'h100+i,0,0);
    add("push_full", 0,1,0,0,'h1FF, 8,'h107,1,0, 8,'h1FF,1,0);
    for (int k = 1; k <= 8; k++)
      add("drain_ovf", 0,0,1,0,0, 8-k,(k<8)?'h107-k:0,1,0, 8-k,(k<8)?'h108-k:0,1,0);
    add("clr_ovf",  0,0,0,1,0, 0,0,0,0, 0,0,0,0);
    add("pop_empty",0,0,1,0,0, 0,0,0,1, 0,0,0,1);
    for (int i = 0; i < 5; i++)
      add("udf_hold", 0,0,0,0,0, 0,0,0,1, 0,0,0,1);
    add("clr_udf",  0,0,0,1,0, 0,0,0,0, 0,0,0,0);
    add("clr_vs_set",0,0,1,1,0, 0,0,0,1, 0,0,0,1);
    add("clr_udf2", 0,0,0,1,0, 0,0,0,0, 0,0,0,0);
    add("push020",  0,1,0,0,'h020, 1,'h020,0,0, 1,'h020,0,0);
    add("push021",  0,1,0,0,'h021, 2,'h021,0,0, 2,'h021,0,0);
    add("pp_0AA",   0,1,1,0,'h0AA, 2,'h0AA,0,0, 2,'h0AA,0,0);
    add("pop_020",  0,0,1,0,0, 1,'h020,0,0, 1,'h020,0,0);
    add("pop_last", 0,0,1,0,0, 0,0,0,0, 0,0,0,0);
    add("pp_empty", 0,1,1,0,'h0BB, 1,'h0BB,0,1, 1,'h0BB,0,1);
    add("rst_mid",  1,0,1,1,0, 0,0,0,0, 0,0,0,0);
    add("post_rst_pop",0,0,1,0,0, 0,0,0,1, 0,0,0,1);
    add("rst_again",1,0,0,0,0, 0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 8; i++)
      add("fill010", 0,1,0,0,'h010+i, i+1,'h010+i,0,0, i+1,'h010+i,0,0);
    add("pp_full",  0,1,1,0,'h0CC, 8,'h0CC,0,0, 8,'h0CC,0,0);
    for (int k = 1; k <= 8; k++)
      add("drain010", 0,0,1,0,0, 8-k,(k<8)?'h017-k:0,0,0, 8-k,(k<8)?'h017-k:0,0,0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, int'(vecs[i].data));
      check_all(vecs[i].name, vecs[i].cs, vecs[i].ts, vecs[i].os, vecs[i].us,
                vecs[i].cw, vecs[i].tw, vecs[i].ow, vecs[i].uw);
    end

    // Randomized phase against the array model; push bias alternates so the
    // stack regularly reaches both full and empty.
    for (int n = 0; n < 2000; n++) begin
      logic r, ps, pp, cl;
      int d, pw;
      pw = ((n / 100) % 2 == 0) ? 70 : 30;
      r  = (n == 0) || ($urandom_range(63) == 0);
      ps = ($urandom_range(99) < pw);
      pp = ($urandom_range(99) < (100 - pw));
      cl = ($urandom_range(7) == 0);
      d  = int'($urandom_range(4095));
      apply(r, ps, pp, cl, d);
      model_step(0, r, ps, pp, cl, d);
      model_step(1, r, ps, pp, cl, d);
      check_all("random", m_cnt[0], m_top(0), m_ovf[0], m_udf[0],
                m_cnt[1], m_top(1), m_ovf[1], m_udf[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
